// File: rtl/mem_arbiter.sv
// Two-port (A/B) arbiter in front of a single data memory. Each access runs
// IDLE -> ACCESS -> RESP; illegal requests skip ACCESS and never reach memory.
module mem_arbiter #(
   parameter int unsigned ADDR_LIMIT = 4096,
   parameter bit          RR_ENABLE  = 1'b1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        A_req,
   input  logic        A_we,
   input  logic [1:0]  A_cmd,
   input  logic [31:0] A_addr,
   input  logic [31:0] A_wdata,
   input  logic        B_req,
   input  logic        B_we,
   input  logic [1:0]  B_cmd,
   input  logic [31:0] B_addr,
   input  logic [31:0] B_wdata,
   output logic        A_ack,
   output logic        A_err,
   output logic [31:0] A_rdata,
   output logic        B_ack,
   output logic        B_err,
   output logic [31:0] B_rdata,
   output logic        M_W_en,
   output logic        M_R_en,
   output logic [31:0] M_Address,
   output logic [31:0] M_W_data,
   output logic [1:0]  M_memReadCommand,
   output logic [1:0]  M_memWriteCommand,
   input  logic [31:0] M_R_data
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

   state_t      state_q, state_d;
   logic        last_q, last_d;   // 0 = A granted last, 1 = B
   logic        gnt_q, gnt_d;
   logic        we_q, we_d;
   logic        a_ack_q, a_ack_d, b_ack_q, b_ack_d;
   logic        a_err_q, a_err_d, b_err_q, b_err_d;
   logic [31:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
   logic        m_wen_q, m_wen_d, m_ren_q, m_ren_d;
   logic [31:0] m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
   logic [1:0]  m_rcmd_q, m_rcmd_d, m_wcmd_q, m_wcmd_d;

   logic        sel_b, w_we, w_bad;
   logic [1:0]  w_cmd;
   logic [31:0] w_addr, w_wdata;

   // Winner selection and legality of the request about to be latched.
   always_comb begin
      if (A_req && B_req) sel_b = RR_ENABLE ? ~last_q : 1'b0;
      else                sel_b = B_req;
      w_we    = sel_b ? B_we    : A_we;
      w_cmd   = sel_b ? B_cmd   : A_cmd;
      w_addr  = sel_b ? B_addr  : A_addr;
      w_wdata = sel_b ? B_wdata : A_wdata;
      w_bad   = (w_cmd == 2'd3) || ((w_cmd == 2'd0) && (w_addr[1:0] != 2'b00)) ||
                ((w_cmd == 2'd1) && w_addr[0]) || (w_addr >= LIMIT);
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      gnt_d     = gnt_q;
      we_d      = we_q;
      a_ack_d   = 1'b0;
      b_ack_d   = 1'b0;
      a_err_d   = 1'b0;
      b_err_d   = 1'b0;
      a_rdata_d = a_rdata_q;
      b_rdata_d = b_rdata_q;
      m_wen_d   = 1'b0;
      m_ren_d   = 1'b0;
      m_addr_d  = '0;
      m_wdata_d = '0;
      m_rcmd_d  = '0;
      m_wcmd_d  = '0;
      case (state_q)
         IDLE: begin
            if (A_req || B_req) begin
               gnt_d  = sel_b;
               last_d = sel_b;
               we_d   = w_we;
               if (w_bad) begin
                  state_d = RESP;
                  if (sel_b) begin
                     b_ack_d   = 1'b1;
                     b_err_d   = 1'b1;
                     b_rdata_d = '0;
                  end else begin
                     a_ack_d   = 1'b1;
                     a_err_d   = 1'b1;
                     a_rdata_d = '0;
                  end
               end else begin
                  state_d   = ACCESS;
                  m_wen_d   = w_we;
                  m_ren_d   = ~w_we;
                  m_addr_d  = w_addr;
                  m_wdata_d = w_wdata;
                  m_rcmd_d  = w_we ? 2'd0 : w_cmd;
                  m_wcmd_d  = w_we ? w_cmd : 2'd0;
               end
            end
         end
         ACCESS: begin
            // Memory data is already lane-selected and extended; take it as-is.
            state_d = RESP;
            if (gnt_q) begin
               b_ack_d = 1'b1;
               if (!we_q) b_rdata_d = M_R_data;
            end else begin
               a_ack_d = 1'b1;
               if (!we_q) a_rdata_d = M_R_data;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         gnt_q     <= 1'b0;
         we_q      <= 1'b0;
         a_ack_q   <= 1'b0;
         b_ack_q   <= 1'b0;
         a_err_q   <= 1'b0;
         b_err_q   <= 1'b0;
         a_rdata_q <= '0;
         b_rdata_q <= '0;
         m_wen_q   <= 1'b0;
         m_ren_q   <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_rcmd_q  <= '0;
         m_wcmd_q  <= '0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         gnt_q     <= gnt_d;
         we_q      <= we_d;
         a_ack_q   <= a_ack_d;
         b_ack_q   <= b_ack_d;
         a_err_q   <= a_err_d;
         b_err_q   <= b_err_d;
         a_rdata_q <= a_rdata_d;
         b_rdata_q <= b_rdata_d;
         m_wen_q   <= m_wen_d;
         m_ren_q   <= m_ren_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_rcmd_q  <= m_rcmd_d;
         m_wcmd_q  <= m_wcmd_d;
      end
   end

   assign A_ack             = a_ack_q;
   assign A_err             = a_err_q;
   assign A_rdata           = a_rdata_q;
   assign B_ack             = b_ack_q;
   assign B_err             = b_err_q;
   assign B_rdata           = b_rdata_q;
   assign M_W_en            = m_wen_q;
   assign M_R_en            = m_ren_q;
   assign M_Address         = m_addr_q;
   assign M_W_data          = m_wdata_q;
   assign M_memReadCommand  = m_rcmd_q;
   assign M_memWriteCommand = m_wcmd_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed table, tie/priority sequences, mid-access
// reset, and random traffic against a byte-array memory reference model.
module tb_mem_arbiter;
   typedef struct packed {
      logic        we;
      logic [1:0]  cmd;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   typedef struct packed {
      logic        pb;
      txn_t        t;
      logic        err;
      logic [31:0] rd;
   } vec_t;

   logic        Clock, Reset;
   logic        A_req, A_we, B_req, B_we;
   logic [1:0]  A_cmd, B_cmd;
   logic [31:0] A_addr, A_wdata, B_addr, B_wdata;
   logic        A_ack, A_err, B_ack, B_err;
   logic [31:0] A_rdata, B_rdata;
   logic        M_W_en, M_R_en;
   logic [31:0] M_Address, M_W_data, M_R_data;
   logic [1:0]  M_memReadCommand, M_memWriteCommand;

   logic        f_A_req, f_A_we, f_B_req, f_B_we;
   logic [1:0]  f_A_cmd, f_B_cmd;
   logic [31:0] f_A_addr, f_A_wdata, f_B_addr, f_B_wdata;
   logic        f_A_ack, f_A_err, f_B_ack, f_B_err;
   logic [31:0] f_A_rdata, f_B_rdata;
   logic        f_M_W_en, f_M_R_en;
   logic [31:0] f_M_Address, f_M_W_data, f_M_R_data;
   logic [1:0]  f_M_memReadCommand, f_M_memWriteCommand;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0]  rmem [0:4095];   // memory seen by the DUT
   logic [7:0]  mmem [0:4095];   // reference model memory
   logic [31:0] mrd_a, mrd_b;
   logic        mlast;

   mem_arbiter #(.ADDR_LIMIT(4096), .RR_ENABLE(1'b1)) dut (
      .Clock(Clock), .Reset(Reset),
      .A_req(A_req), .A_we(A_we), .A_cmd(A_cmd), .A_addr(A_addr), .A_wdata(A_wdata),
      .B_req(B_req), .B_we(B_we), .B_cmd(B_cmd), .B_addr(B_addr), .B_wdata(B_wdata),
      .A_ack(A_ack), .A_err(A_err), .A_rdata(A_rdata),
      .B_ack(B_ack), .B_err(B_err), .B_rdata(B_rdata),
      .M_W_en(M_W_en), .M_R_en(M_R_en), .M_Address(M_Address), .M_W_data(M_W_data),
      .M_memReadCommand(M_memReadCommand), .M_memWriteCommand(M_memWriteCommand),
      .M_R_data(M_R_data)
   );

   mem_arbiter #(.ADDR_LIMIT(4096), .RR_ENABLE(1'b0)) dut_fp (
      .Clock(Clock), .Reset(Reset),
      .A_req(f_A_req), .A_we(f_A_we), .A_cmd(f_A_cmd), .A_addr(f_A_addr), .A_wdata(f_A_wdata),
      .B_req(f_B_req), .B_we(f_B_we), .B_cmd(f_B_cmd), .B_addr(f_B_addr), .B_wdata(f_B_wdata),
      .A_ack(f_A_ack), .A_err(f_A_err), .A_rdata(f_A_rdata),
      .B_ack(f_B_ack), .B_err(f_B_err), .B_rdata(f_B_rdata),
      .M_W_en(f_M_W_en), .M_R_en(f_M_R_en), .M_Address(f_M_Address), .M_W_data(f_M_W_data),
      .M_memReadCommand(f_M_memReadCommand), .M_memWriteCommand(f_M_memWriteCommand),
      .M_R_data(f_M_R_data)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   // Memory responder: read data appears at the negedge of the access cycle.
   always @(negedge Clock) begin : rd_port
      int a;
      a = int'(M_Address[11:0]);
      if (M_R_en) begin
         case (M_memReadCommand)
            2'd0:    M_R_data <= {rmem[a+3], rmem[a+2], rmem[a+1], rmem[a]};
            2'd1:    M_R_data <= {{16{rmem[a+1][7]}}, rmem[a+1], rmem[a]};
            default: M_R_data <= {{24{rmem[a][7]}}, rmem[a]};
         endcase
      end else begin
         M_R_data <= $urandom;
      end
   end

   always @(posedge Clock) begin : wr_port
      int a;
      a = int'(M_Address[11:0]);
      if (M_W_en) begin
         rmem[a] = M_W_data[7:0];
         if (M_memWriteCommand != 2'd2) rmem[a+1] = M_W_data[15:8];
         if (M_memWriteCommand == 2'd0) begin
            rmem[a+2] = M_W_data[23:16];
            rmem[a+3] = M_W_data[31:24];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic bit illegal(input logic [1:0] cmd, input logic [31:0] addr);
      return (cmd == 2'd3) || (cmd == 2'd0 && addr % 4 != 0) ||
             (cmd == 2'd1 && addr % 2 != 0) || (addr >= 32'd4096);
   endfunction

   function automatic logic [31:0] mload(input logic [1:0] cmd, input logic [31:0] addr);
      int i;
      i = int'(addr[11:0]);
      case (cmd)
         2'd0:    return {mmem[i+3], mmem[i+2], mmem[i+1], mmem[i]};
         2'd1:    return 32'($signed({mmem[i+1], mmem[i]}));
         default: return 32'($signed(mmem[i]));
      endcase
   endfunction

   task automatic model_step(input logic pb, input txn_t t, output logic err, output logic [31:0] rd);
      int i;
      i   = int'(t.addr[11:0]);
      err = illegal(t.cmd, t.addr);
      rd  = pb ? mrd_b : mrd_a;
      if (err) rd = 32'h0;
      else if (!t.we) rd = mload(t.cmd, t.addr);
      else begin
         for (int k = 0; k < (t.cmd == 2'd0 ? 4 : t.cmd == 2'd1 ? 2 : 1); k++)
            mmem[i+k] = 8'(t.wdata >> (8*k));
      end
      if (pb) mrd_b = rd; else mrd_a = rd;
      mlast = pb;
   endtask

   function automatic txn_t rnd_txn();
      txn_t t;
      int   r;
      t.we    = 1'($urandom_range(0, 1));
      t.cmd   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      t.wdata = $urandom;
      r = int'($urandom_range(0, 19));
      if (r == 0)      t.addr = 32'h1000 + 32'($urandom_range(0, 3) * 4);
      else if (r == 1) t.addr = 32'hFFFF_FFFC;
      else begin
         t.addr = 32'($urandom_range(0, 63)) + ((r < 5) ? 32'hFC0 : 32'h40);
         if (r < 16 && t.cmd == 2'd0) t.addr[1:0] = 2'b00;
         if (r < 16 && t.cmd == 2'd1) t.addr[0] = 1'b0;
      end
      return t;
   endfunction

   // Presents up to two requests at once from IDLE and checks ack timing,
   // err, rdata, pulse widths and memory-enable counts.
   task automatic run_txns(input bit ea, input txn_t ta, input bit eb, input txn_t tb,
                           input bit first_b, input logic ea_err, input logic [31:0] ea_rd,
                           input logic eb_err, input logic [31:0] eb_rd);
      int lat_a, lat_b, exp_ca, exp_cb, cyc, got_a, got_b, nr, nw, exp_nr, exp_nw;
      lat_a = ea_err ? 1 : 2;
      lat_b = eb_err ? 1 : 2;
      if (ea && eb) begin
         if (first_b) begin exp_cb = lat_b; exp_ca = lat_b + 1 + lat_a; end
         else         begin exp_ca = lat_a; exp_cb = lat_a + 1 + lat_b; end
      end else begin
         exp_ca = lat_a;
         exp_cb = lat_b;
      end
      exp_nr = int'(ea && !ea_err && !ta.we) + int'(eb && !eb_err && !tb.we);
      exp_nw = int'(ea && !ea_err && ta.we) + int'(eb && !eb_err && tb.we);
      A_req = ea; A_we = ta.we; A_cmd = ta.cmd; A_addr = ta.addr; A_wdata = ta.wdata;
      B_req = eb; B_we = tb.we; B_cmd = tb.cmd; B_addr = tb.addr; B_wdata = tb.wdata;
      cyc = 0; got_a = 0; got_b = 0; nr = 0; nw = 0;
      while (((ea && got_a == 0) || (eb && got_b == 0)) && cyc < 16) begin
         @(negedge Clock);
         cyc++;
         if (M_R_en) nr++;
         if (M_W_en) nw++;
         if (A_ack) begin
            got_a++;
            chk("A ack cycle", 32'(cyc), 32'(exp_ca));
            chk("A err", 32'(A_err), 32'(ea_err));
            chk("A rdata", A_rdata, ea_rd);
            A_req = 1'b0;
         end
         if (B_ack) begin
            got_b++;
            chk("B ack cycle", 32'(cyc), 32'(exp_cb));
            chk("B err", 32'(B_err), 32'(eb_err));
            chk("B rdata", B_rdata, eb_rd);
            B_req = 1'b0;
         end
         // Disturb the granted port's inputs mid-access; the latched copy must be used.
         if (cyc == 1 && !first_b && A_req) begin A_addr = $urandom; A_wdata = $urandom; A_cmd = 2'($urandom); end
         if (cyc == 1 && first_b && B_req)  begin B_addr = $urandom; B_wdata = $urandom; B_cmd = 2'($urandom); end
      end
      chk("A ack count", 32'(got_a), 32'(ea));
      chk("B ack count", 32'(got_b), 32'(eb));
      @(negedge Clock);
      chk("ack single pulse", 32'({A_ack, B_ack}), 32'h0);
      chk("M_R_en cycles", 32'(nr), 32'(exp_nr));
      chk("M_W_en cycles", 32'(nw), 32'(exp_nw));
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin : main
      vec_t        tbl [14];
      txn_t        ta, tb, tz;
      logic        e1, e2;
      logic [31:0] r1, r2, w20;
      int          cyc, na, nb;
      bit          ea, eb, fb, got;

      for (int i = 0; i < 4096; i++) begin rmem[i] = 8'h0; mmem[i] = 8'h0; end
      {rmem[19], rmem[18], rmem[17], rmem[16]} = 32'h8000_1234;
      {mmem[19], mmem[18], mmem[17], mmem[16]} = 32'h8000_1234;
      mrd_a = 32'h0; mrd_b = 32'h0; mlast = 1'b1;
      tz = '0;

      tbl[0]  = '{1'b0, '{1'b0, 2'd0, 32'h10,   32'h0},        1'b0, 32'h8000_1234};
      tbl[1]  = '{1'b1, '{1'b1, 2'd2, 32'h13,   32'h5555_55AB}, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, '{1'b0, 2'd2, 32'h13,   32'h0},        1'b0, 32'hFFFF_FFAB};
      tbl[3]  = '{1'b1, '{1'b1, 2'd1, 32'h12,   32'h1234_7F00}, 1'b0, 32'hFFFF_FFAB};
      tbl[4]  = '{1'b1, '{1'b0, 2'd1, 32'h12,   32'h0},        1'b0, 32'h0000_7F00};
      tbl[5]  = '{1'b0, '{1'b0, 2'd0, 32'h6,    32'h0},        1'b1, 32'h0};
      tbl[6]  = '{1'b0, '{1'b0, 2'd1, 32'h5,    32'h0},        1'b1, 32'h0};
      tbl[7]  = '{1'b1, '{1'b0, 2'd3, 32'h0,    32'h0},        1'b1, 32'h0};
      tbl[8]  = '{1'b0, '{1'b0, 2'd0, 32'h1000, 32'h0},        1'b1, 32'h0};
      tbl[9]  = '{1'b0, '{1'b0, 2'd2, 32'hFFF,  32'h0},        1'b0, 32'h0};
      tbl[10] = '{1'b0, '{1'b1, 2'd0, 32'hFFC,  32'h1234_5678}, 1'b0, 32'h0};
      tbl[11] = '{1'b0, '{1'b0, 2'd0, 32'hFFC,  32'h0},        1'b0, 32'h1234_5678};
      tbl[12] = '{1'b0, '{1'b1, 2'd1, 32'h11,   32'hFFFF_FFFF}, 1'b1, 32'h0};
      tbl[13] = '{1'b1, '{1'b0, 2'd0, 32'h10,   32'h0},        1'b0, 32'h7F00_1234};

      A_req = 0; A_we = 0; A_cmd = 0; A_addr = 0; A_wdata = 0;
      B_req = 0; B_we = 0; B_cmd = 0; B_addr = 0; B_wdata = 0;
      f_A_req = 0; f_A_we = 0; f_A_cmd = 0; f_A_addr = 32'h0; f_A_wdata = 0;
      f_B_req = 0; f_B_we = 0; f_B_cmd = 0; f_B_addr = 32'h4; f_B_wdata = 0;
      f_M_R_data = 32'h0000_00F0;
      Reset = 1'b1;
      #2 Reset = 1'b0;
      #1;
      chk("reset acks", 32'({A_ack, B_ack, A_err, B_err}), 32'h0);
      chk("reset A_rdata", A_rdata, 32'h0);
      chk("reset B_rdata", B_rdata, 32'h0);
      chk("reset M enables", 32'({M_W_en, M_R_en}), 32'h0);
      chk("reset M_Address", M_Address, 32'h0);
      chk("reset M_W_data", M_W_data, 32'h0);
      chk("reset M commands", 32'({M_memReadCommand, M_memWriteCommand}), 32'h0);
      @(negedge Clock);
      @(negedge Clock);
      Reset = 1'b1;

      // Directed single-port table.
      foreach (tbl[i]) begin
         model_step(tbl[i].pb, tbl[i].t, e1, r1);
         run_txns(!tbl[i].pb, tbl[i].t, tbl[i].pb, tbl[i].t, tbl[i].pb,
                  tbl[i].err, tbl[i].rd, tbl[i].err, tbl[i].rd);
      end

      // Three simultaneous requests with round-robin: grants go A, B, A, B, ...
      ta = '{1'b0, 2'd0, 32'h10, 32'h0};
      tb = '{1'b0, 2'd2, 32'h14, 32'h0};
      for (int k = 0; k < 3; k++) begin
         model_step(1'b0, ta, e1, r1);
         model_step(1'b1, tb, e2, r2);
         run_txns(1'b1, ta, 1'b1, tb, 1'b0, e1, r1, e2, r2);
      end

      // Random traffic against the reference model.
      for (int k = 0; k < 60; k++) begin
         ea = 1'($urandom_range(0, 1));
         eb = ea ? 1'($urandom_range(0, 1)) : 1'b1;
         ta = rnd_txn();
         tb = rnd_txn();
         fb = (ea && eb) ? ~mlast : eb;
         if (fb) begin
            model_step(1'b1, tb, e2, r2);
            if (ea) model_step(1'b0, ta, e1, r1);
         end else begin
            model_step(1'b0, ta, e1, r1);
            if (eb) model_step(1'b1, tb, e2, r2);
         end
         run_txns(ea, ta, eb, tb, fb, e1, r1, e2, r2);
      end

      // Reset in the middle of a store's ACCESS cycle.
      w20 = mload(2'd0, 32'h20);
      A_req = 1'b1; A_we = 1'b1; A_cmd = 2'd0; A_addr = 32'h20; A_wdata = 32'hDEAD_BEEF;
      @(posedge Clock);
      #2;
      chk("store M_W_en in ACCESS", 32'(M_W_en), 32'h1);
      chk("store M_W_data", M_W_data, 32'hDEAD_BEEF);
      Reset = 1'b0;
      #1;
      chk("reset drops M_W_en", 32'(M_W_en), 32'h0);
      chk("reset clears M_Address", M_Address, 32'h0);
      A_req = 1'b0;
      @(negedge Clock);
      @(negedge Clock);
      chk("no ack under reset", 32'({A_ack, B_ack}), 32'h0);
      chk("aborted store not committed", {rmem[35], rmem[34], rmem[33], rmem[32]}, w20);
      chk("reset A_rdata cleared", A_rdata, 32'h0);
      chk("reset B_rdata cleared", B_rdata, 32'h0);
      mrd_a = 32'h0; mrd_b = 32'h0; mlast = 1'b1;
      Reset = 1'b1;
      ta = '{1'b0, 2'd0, 32'h20, 32'h0};
      model_step(1'b0, ta, e1, r1);
      run_txns(1'b1, ta, 1'b0, tz, 1'b0, e1, r1, 1'b0, 32'h0);

      // Fixed priority: A keeps re-requesting and starves B until it lets go.
      f_A_req = 1'b1; f_B_req = 1'b1;
      na = 0; nb = 0; cyc = 0;
      while (na < 3 && cyc < 20) begin
         @(negedge Clock);
         cyc++;
         if (f_A_ack) begin na++; if (na == 3) f_A_req = 1'b0; end
         if (f_B_ack) nb++;
      end
      chk("fp A acks", 32'(na), 32'd3);
      chk("fp B waits", 32'(nb), 32'd0);
      chk("fp throughput cycles", 32'(cyc), 32'd8);
      cyc = 0; got = 1'b0;
      while (!got && cyc < 10) begin
         @(negedge Clock);
         cyc++;
         if (f_B_ack) got = 1'b1;
      end
      f_B_req = 1'b0;
      chk("fp B served", 32'(got), 32'h1);
      chk("fp B ack cycle", 32'(cyc), 32'd3);
      chk("fp B rdata", f_B_rdata, 32'h0000_00F0);
      chk("fp A rdata", f_A_rdata, 32'h0000_00F0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
